// File: rtl/matrix_memory.sv
// NUM_ROWS x NUM_COLS register-file matrix store with registered row/column read
// ports, a single-element write port and a row-serial clear engine.
module matrix_memory #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 5,
    parameter int WIDTH          = 32,
    parameter int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    parameter int COL_ADDR_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROW_ADDR_WIDTH-1:0] row_addr,
    input  logic                      row_addr_ready,
    output logic                      row_valid,
    output logic [NUM_COLS*WIDTH-1:0] row_out,
    input  logic [COL_ADDR_WIDTH-1:0] col_addr,
    input  logic                      col_addr_ready,
    output logic                      col_valid,
    output logic [NUM_ROWS*WIDTH-1:0] col_out,
    input  logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
    input  logic [COL_ADDR_WIDTH-1:0] write_col_addr,
    input  logic [WIDTH-1:0]          write_data,
    input  logic                      write_ready,
    input  logic                      clear,
    output logic                      busy
);

    typedef enum logic {IDLE, CLEARING} state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(NUM_ROWS - 1);

    logic [WIDTH-1:0]          mem [NUM_ROWS][NUM_COLS];
    state_t                    state, state_next;
    logic [ROW_ADDR_WIDTH-1:0] clr_row, clr_row_next;
    logic                      idle;
    logic                      write_en;
    logic                      row_accept, col_accept;
    logic [NUM_COLS*WIDTH-1:0] row_sel;
    logic [NUM_ROWS*WIDTH-1:0] col_sel;

    assign idle       = (state == IDLE);
    assign busy       = (state == CLEARING);
    // A clear in the same idle cycle wins over the element write.
    assign write_en   = idle && !clear && write_ready;
    assign row_accept = idle && row_addr_ready;
    assign col_accept = idle && col_addr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_row <= '0;
        end else begin
            state   <= state_next;
            clr_row <= clr_row_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_row_next = clr_row;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next   = CLEARING;
                    clr_row_next = '0;
                end
            end
            CLEARING: begin
                if (clr_row == LAST_ROW) begin
                    state_next   = IDLE;
                    clr_row_next = '0;
                end else begin
                    clr_row_next = clr_row + ROW_ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                clr_row_next = '0;
            end
        endcase
    end

    // Address compare per row/column: out-of-range addresses match nothing,
    // so writes are ignored and reads return zero without extra range logic.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (busy && clr_row == ROW_ADDR_WIDTH'(r)) begin
                    mem[r][c] <= '0;
                end else if (write_en && write_row_addr == ROW_ADDR_WIDTH'(r)
                             && write_col_addr == COL_ADDR_WIDTH'(c)) begin
                    mem[r][c] <= write_data;
                end
            end
        end
    end

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (row_addr == ROW_ADDR_WIDTH'(r)) begin
                    row_sel[c*WIDTH +: WIDTH] = mem[r][c];
                end
                if (col_addr == COL_ADDR_WIDTH'(c)) begin
                    col_sel[r*WIDTH +: WIDTH] = mem[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_valid <= 1'b0;
            row_out   <= '0;
            col_valid <= 1'b0;
            col_out   <= '0;
        end else begin
            row_valid <= row_accept;
            col_valid <= col_accept;
            if (row_accept) begin
                row_out <= row_sel;
            end
            if (col_accept) begin
                col_out <= col_sel;
            end
        end
    end

endmodule
